// File: rtl/ins_fetch_queue_if.sv
// Handshake bundle for ins_fetch_queue: control inputs, ROM port and instruction queue head.
// stall_cnt exists only when INSQ_STALL_CNT_EN is defined.
interface ins_fetch_queue_if;
    logic        en;
    logic        pc_load;
    logic [15:0] pc_load_addr;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        ins_valid;
    logic [15:0] ins_data;
    logic [15:0] ins_addr;
    logic        ins_ready;
    logic [3:0]  q_count;
    logic        q_full;
    logic        q_empty;
`ifdef INSQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    modport slave (
        input  en, pc_load, pc_load_addr, rom_data, ins_ready,
`ifdef INSQ_STALL_CNT_EN
        output stall_cnt,
`endif
        output rom_addr, ins_valid, ins_data, ins_addr, q_count, q_full, q_empty
    );

    modport master (
        output en, pc_load, pc_load_addr, rom_data, ins_ready,
`ifdef INSQ_STALL_CNT_EN
        input  stall_cnt,
`endif
        input  rom_addr, ins_valid, ins_data, ins_addr, q_count, q_full, q_empty
    );
endinterface

// File: rtl/ins_fetch_queue.sv
// Instruction prefetch queue in front of a synchronous ROM: issues one address per cycle while
// space (queue + in-flight) remains, flushes on pc_load. Optional stall counter: INSQ_STALL_CNT_EN.
module ins_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    ins_fetch_queue_if.slave bus
);
    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [PW-1:0]   PTR_ZERO = PW'(0);
    localparam logic [4:0]      DEPTH_W  = 5'(DEPTH);
    localparam logic [3:0]      DEPTH_C  = 4'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic          pending_q, pending_d;
    logic [15:0]   pend_addr_q, pend_addr_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [3:0]    count_q, count_d;
    logic          ins_valid_q, ins_valid_d;
    logic          q_full_q, q_full_d;
    logic          q_empty_q, q_empty_d;
    logic [15:0]   ins_data_q, ins_data_d;
    logic [15:0]   ins_addr_q, ins_addr_d;
    logic          issue_s, push_s, pop_s;

    // Next-state: flush has priority; otherwise issue, complete the pending read, and pop.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        pending_d   = pending_q;
        pend_addr_d = pend_addr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        issue_s     = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (bus.pc_load) begin
            state_d    = ST_FLUSH;
            fetch_pc_d = bus.pc_load_addr;
            pending_d  = 1'b0;
            rd_ptr_d   = PTR_ZERO;
            wr_ptr_d   = PTR_ZERO;
            count_d    = 4'd0;
        end else begin
            // Credit counts the in-flight word; a same-cycle pop does not free a slot.
            issue_s = bus.en && (({1'b0, count_q} + {4'd0, pending_q}) < DEPTH_W);
            push_s  = pending_q;
            pop_s   = ins_valid_q && bus.ins_ready;
            state_d = bus.en ? ST_RUN : ST_IDLE;

            // A pending read always lands this cycle, so pending only survives via a new issue.
            pending_d = issue_s;
            if (issue_s) begin
                pend_addr_d = fetch_pc_q;
                fetch_pc_d  = fetch_pc_q + 16'd1;
            end else begin
                pend_addr_d = pend_addr_q;
                fetch_pc_d  = fetch_pc_q;
            end

            if (push_s) begin
                mem_d[wr_ptr_q] = {bus.rom_data, pend_addr_q};
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 4'd1;
                2'b01:   count_d = count_q - 4'd1;
                default: count_d = count_q;
            endcase
        end

        ins_valid_d = (count_d != 4'd0);
        q_empty_d   = (count_d == 4'd0);
        q_full_d    = (count_d == DEPTH_C);
        if (ins_valid_d) begin
            ins_data_d = mem_d[rd_ptr_d][31:16];
            ins_addr_d = mem_d[rd_ptr_d][15:0];
        end else begin
            ins_data_d = 16'h0000;
            ins_addr_d = 16'h0000;
        end
    end

    // State, queue storage and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= 16'h0000;
            pending_q   <= 1'b0;
            pend_addr_q <= 16'h0000;
            rd_ptr_q    <= PTR_ZERO;
            wr_ptr_q    <= PTR_ZERO;
            count_q     <= 4'd0;
            ins_valid_q <= 1'b0;
            q_full_q    <= 1'b0;
            q_empty_q   <= 1'b1;
            ins_data_q  <= 16'h0000;
            ins_addr_q  <= 16'h0000;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            pending_q   <= pending_d;
            pend_addr_q <= pend_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ins_valid_q <= ins_valid_d;
            q_full_q    <= q_full_d;
            q_empty_q   <= q_empty_d;
            ins_data_q  <= ins_data_d;
            ins_addr_q  <= ins_addr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.rom_addr  = fetch_pc_q;
    assign bus.ins_valid = ins_valid_q;
    assign bus.ins_data  = ins_data_q;
    assign bus.ins_addr  = ins_addr_q;
    assign bus.q_count   = count_q;
    assign bus.q_full    = q_full_q;
    assign bus.q_empty   = q_empty_q;

`ifdef INSQ_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles the head waits on the splitter; redirect clears it.
    always_comb begin
        if (bus.pc_load) begin
            stall_cnt_d = 16'h0000;
        end else if (ins_valid_q && !bus.ins_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_ins_fetch_queue.sv
// Bench for ins_fetch_queue: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations (latency, full, flush, wrap, reset, optional stall counter).
module tb_ins_fetch_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    ins_fetch_queue_if bus();

    ins_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    // Synchronous ROM: word for the address presented at the edge appears after it.
    always @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);

    // Reference model: list of {word, addr} in the queue, fetch pointer, one in-flight read.
    logic [31:0] mq[$];
    logic [15:0] m_pc;
    logic [15:0] m_pend_addr;
    bit          m_pend;
    bit          m_issue;
    int          m_stall;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pc        = 16'h0000;
            m_pend      = 1'b0;
            m_pend_addr = 16'h0000;
            m_stall     = 0;
        end else if (bus.pc_load) begin
            mq.delete();
            m_pend  = 1'b0;
            m_pc    = bus.pc_load_addr;
            m_stall = 0;
        end else begin
            if (mq.size() != 0 && !bus.ins_ready && m_stall < 65535) m_stall++;
            m_issue = bus.en && ((mq.size() + int'(m_pend)) < DEPTH);
            if (mq.size() != 0 && bus.ins_ready) void'(mq.pop_front());
            if (m_pend) mq.push_back({rom_word(m_pend_addr), m_pend_addr});
            m_pend = m_issue;
            if (m_issue) begin
                m_pend_addr = m_pc;
                m_pc        = m_pc + 16'd1;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            cmp("m_ins_valid", 32'(bus.ins_valid), 32'(mq.size() != 0));
            cmp("m_q_count",   32'(bus.q_count),   32'(mq.size()));
            cmp("m_q_full",    32'(bus.q_full),    32'(mq.size() == DEPTH));
            cmp("m_q_empty",   32'(bus.q_empty),   32'(mq.size() == 0));
            cmp("m_rom_addr",  32'(bus.rom_addr),  32'(m_pc));
            if (mq.size() != 0) begin
                cmp("m_ins_data", 32'(bus.ins_data), 32'(mq[0][31:16]));
                cmp("m_ins_addr", 32'(bus.ins_addr), 32'(mq[0][15:0]));
            end
`ifdef INSQ_STALL_CNT_EN
            cmp("m_stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hard_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        bus.en        = 1'b0;
        bus.ins_ready = 1'b0;
        bus.pc_load   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] pat_en  = 32'hF3F0_FF7C;
    logic [31:0] pat_rdy = 32'h5A3C_96E1;
    logic [15:0] ea;

    initial begin
        rst_n            = 1'b0;
        bus.en           = 1'b0;
        bus.pc_load      = 1'b0;
        bus.pc_load_addr = 16'h0000;
        bus.ins_ready    = 1'b0;
        step(2);
        cmp("rst_rom_addr",  32'(bus.rom_addr),  32'h0);
        cmp("rst_q_count",   32'(bus.q_count),   32'h0);
        cmp("rst_ins_valid", 32'(bus.ins_valid), 32'h0);
        cmp("rst_ins_data",  32'(bus.ins_data),  32'h0);
        cmp("rst_ins_addr",  32'(bus.ins_addr),  32'h0);
        cmp("rst_q_empty",   32'(bus.q_empty),   32'h1);
        cmp("rst_q_full",    32'(bus.q_full),    32'h0);
        rst_n = 1'b1;
        step(2);
        cmp("idle_rom_addr", 32'(bus.rom_addr), 32'h0);

        // Streaming from reset: first word two cycles after en.
        bus.en        = 1'b1;
        bus.ins_ready = 1'b1;
        step(1);
        cmp("lat_valid_c1", 32'(bus.ins_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            cmp("stream_valid", 32'(bus.ins_valid), 32'h1);
            cmp("stream_data",  32'(bus.ins_data),  32'hA000 + i);
            cmp("stream_addr",  32'(bus.ins_addr),  i);
        end

        // Splitter stalled: queue fills, fetch stops at 4.
        hard_reset();
        bus.en        = 1'b1;
        bus.ins_ready = 1'b0;
        step(10);
        cmp("full_q_count",  32'(bus.q_count),  32'h4);
        cmp("full_q_full",   32'(bus.q_full),   32'h1);
        cmp("full_rom_addr", 32'(bus.rom_addr), 32'h4);
        cmp("full_ins_data", 32'(bus.ins_data), 32'hA000);
        cmp("full_ins_addr", 32'(bus.ins_addr), 32'h0);
`ifdef INSQ_STALL_CNT_EN
        cmp("stall_full", 32'(bus.stall_cnt), 32'd8);
        bus.pc_load      = 1'b1;
        bus.pc_load_addr = 16'h0100;
        step(1);
        bus.pc_load = 1'b0;
        cmp("stall_clr", 32'(bus.stall_cnt), 32'd0);
        step(2);
        cmp("stall_valid", 32'(bus.ins_valid), 32'h1);
        step(5);
        cmp("stall_five", 32'(bus.stall_cnt), 32'd5);
`endif

        // Redirect with 3 queued and one read in flight.
        hard_reset();
        bus.en        = 1'b1;
        bus.ins_ready = 1'b0;
        step(4);
        cmp("pre_flush_count", 32'(bus.q_count), 32'h3);
        bus.pc_load      = 1'b1;
        bus.pc_load_addr = 16'h0040;
        step(1);
        bus.pc_load   = 1'b0;
        bus.ins_ready = 1'b1;
        cmp("flush_count",    32'(bus.q_count),   32'h0);
        cmp("flush_rom_addr", 32'(bus.rom_addr),  32'h0040);
        cmp("flush_valid",    32'(bus.ins_valid), 32'h0);
        step(1);
        cmp("flush_valid2", 32'(bus.ins_valid), 32'h0);
        step(1);
        cmp("flush_data",  32'(bus.ins_data), 32'hA040);
        cmp("flush_addr",  32'(bus.ins_addr), 32'h0040);
        step(1);
        cmp("flush_data2", 32'(bus.ins_data), 32'hA041);

        // Back-to-back redirects: the last address wins.
        bus.pc_load      = 1'b1;
        bus.pc_load_addr = 16'h1234;
        step(1);
        bus.pc_load_addr = 16'h0050;
        step(1);
        bus.pc_load = 1'b0;
        cmp("dbl_rom_addr", 32'(bus.rom_addr), 32'h0050);
        cmp("dbl_count",    32'(bus.q_count),  32'h0);
        step(2);
        cmp("dbl_addr", 32'(bus.ins_addr), 32'h0050);
        cmp("dbl_data", 32'(bus.ins_data), 32'hA050);

        // Address wrap at 16'hFFFF.
        bus.pc_load      = 1'b1;
        bus.pc_load_addr = 16'hFFFE;
        step(1);
        bus.pc_load = 1'b0;
        step(1);
        ea = 16'hFFFE;
        for (int i = 0; i < 4; i++) begin
            step(1);
            cmp("wrap_addr", 32'(bus.ins_addr), 32'(ea));
            cmp("wrap_data", 32'(bus.ins_data), 32'(rom_word(ea)));
            ea = ea + 16'd1;
        end

        // Mixed en / ins_ready patterns, including en falling with a read in flight.
        for (int i = 0; i < 32; i++) begin
            bus.en        = pat_en[i];
            bus.ins_ready = pat_rdy[i];
            step(1);
        end

        // Asynchronous reset with two entries queued.
        hard_reset();
        bus.en        = 1'b1;
        bus.ins_ready = 1'b0;
        step(3);
        cmp("pre_rst_count", 32'(bus.q_count), 32'h2);
        #1 rst_n = 1'b0;
        #1;
        cmp("arst_q_count",   32'(bus.q_count),   32'h0);
        cmp("arst_ins_valid", 32'(bus.ins_valid), 32'h0);
        cmp("arst_rom_addr",  32'(bus.rom_addr),  32'h0);
        cmp("arst_ins_data",  32'(bus.ins_data),  32'h0);
        cmp("arst_ins_addr",  32'(bus.ins_addr),  32'h0);
        cmp("arst_q_empty",   32'(bus.q_empty),   32'h1);
        cmp("arst_q_full",    32'(bus.q_full),    32'h0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.ins_ready = 1'b1;
        step(2);
        cmp("refetch_addr", 32'(bus.ins_addr), 32'h0);
        cmp("refetch_data", 32'(bus.ins_data), 32'hA000);
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ins_fetch_queue.md
INS_FETCH_QUEUE -- requirements
Module: ins_fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of queue entries; power of two, 2..8.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: en  input  1  fetch enable; 0 stops new ROM requests, queue contents held.
REQ-005 Port: pc_load  input  1  redirect/flush strobe from control.
REQ-006 Port: pc_load_addr  input  16  new fetch address on redirect.
REQ-007 Port: rom_addr  output  16  address to synchronous instruction ROM; equals internal fetch_pc.
REQ-008 Port: rom_data  input  16  ROM word; valid the cycle after the address was issued.
REQ-009 Port: ins_valid  output  1  queue head holds a valid instruction.
REQ-010 Port: ins_data  output  16  instruction word at queue head, to instruction splitter.
REQ-011 Port: ins_addr  output  16  ROM address of the head instruction.
REQ-012 Port: ins_ready  input  1  splitter accepts head this cycle.
REQ-013 Port: q_count  output  4  number of valid entries, 0..DEPTH.
REQ-014 Port: q_full / q_empty  output  1 each  q_count==DEPTH / q_count==0.

Function
REQ-015 States: IDLE (en=0), RUN (en=1, issuing when space), FLUSH (one cycle, entered on pc_load).
REQ-016 Issue condition in RUN: en=1, pc_load=0, q_count + pending < DEPTH; pops in the same cycle give no credit.
REQ-017 On issue: pending<=1, pend_addr<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^16, 16'hFFFF wraps to 16'h0000).
REQ-018 Cycle after issue with pending=1 and no flush: {rom_data, pend_addr} written at tail; q_count increments unless a pop occurs in the same cycle.
REQ-019 Pop: ins_valid & ins_ready removes head; simultaneous push and pop leaves q_count unchanged.
REQ-020 ins_valid = !q_empty; ins_data/ins_addr are head entry, held stable while ins_valid & !ins_ready.
REQ-021 Max throughput: one instruction per cycle sustained when ins_ready=1 and DEPTH>=2.
REQ-022 Fetch latency: first instruction visible on ins_valid two cycles after en rises from reset (issue cycle + write cycle).
REQ-023 pc_load in cycle N (priority over en, issue, push, pop): queue emptied, pending response dropped, fetch_pc<=pc_load_addr; state FLUSH in N+1 issues rom_addr=pc_load_addr if en=1, then RUN.
REQ-024 pc_load asserted on consecutive cycles: last pc_load_addr wins; no stale word ever enters the queue.
REQ-025 en falling: no new issue; a pending response still completes into the queue.
REQ-026 Pop on empty queue ignored; push on full cannot occur by REQ-016.

Reset
REQ-027 rst_n=0 asynchronously: fetch_pc=16'h0000, rom_addr=16'h0000, pending=0, q_count=0, ins_valid=0, ins_data=0, ins_addr=0, q_empty=1, q_full=0, state IDLE.
REQ-028 Reset mid-fetch discards queue and pending response; first fetch after release is address 0.

Configuration
REQ-029 Macro INSQ_STALL_CNT_EN defined: extra output stall_cnt (16 bits), reset 0, increments each cycle with ins_valid=1 & ins_ready=0, saturates at 16'hFFFF, cleared by pc_load.
REQ-030 Macro undefined: stall_cnt port and counter absent; all other behaviour identical.

Verification
REQ-031 Reset, en=1, ins_ready=1, ROM[i]=16'hA000+i -> ins_valid first high cycle 2, ins_data A000, A001, A002... one per cycle, ins_addr 0,1,2.
REQ-032 ins_ready=0 for 10 cycles, DEPTH=4 -> q_count reaches 4, q_full=1, rom_addr stops at 4, head stays A000/addr 0.
REQ-033 Queue holding 3 entries, pc_load=1 with pc_load_addr=16'h0040 while a response is pending -> next cycle q_count=0, rom_addr=0x0040, next ins_data=ROM[0x40], no ROM[old] seen.
REQ-034 fetch_pc=16'hFFFE, free-run -> ins_addr sequence FFFE, FFFF, 0000, 0001.
REQ-035 rst_n low mid-stream with 2 entries queued -> outputs return to REQ-027 values same cycle, refetch from 0 after release.
REQ-036 INSQ_STALL_CNT_EN defined, ins_ready=0 for 5 cycles with ins_valid=1 -> stall_cnt=5; pc_load -> stall_cnt=0.
